// File: rtl/accum_drain.sv
// Captures finished accumulator blocks into a two-slot buffer and streams them
// lane by lane, with sequential addresses, to the result-memory write port.
module accum_drain #(
  parameter int WORD_W    = 16,
  parameter int LANES     = 16,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      accumulator_done,
  input  logic [WORD_W*LANES-1:0]   in_block,
  output logic [WORD_W-1:0]         out_word,
  output logic [ADDR_W-1:0]         out_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      drain_done,
  output logic                      busy,
  output logic                      overrun,
  output logic [7:0]                block_count
);

  localparam int BLOCK_W = WORD_W * LANES;
  localparam int LANE_W  = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} stateT;

  stateT               r_state;
  stateT               w_nextState;
  logic                r_doneQ;
  logic [BLOCK_W-1:0]  r_slot [2];
  logic                r_wrPtr;
  logic                r_rdPtr;
  logic [1:0]          r_count;
  logic [BLOCK_W-1:0]  r_shift;
  logic [LANE_W-1:0]   r_lane;
  logic                r_overrun;
  logic [7:0]          r_blockCount;

  logic                w_cap;
  logic                w_pop;
  logic                w_drop;
  logic                w_push;
  logic                w_lastLane;
  logic [ADDR_W-1:0]   w_addr;

  // A full buffer only refuses a new block if no slot is freed in the same cycle.
  assign w_cap      = accumulator_done && !r_doneQ;
  assign w_pop      = (r_state == DONE);
  assign w_drop     = w_cap && (r_count == 2'd2) && !w_pop;
  assign w_push     = w_cap && !w_drop;
  assign w_lastLane = (r_lane == LANE_W'(LANES - 1));
  assign w_addr     = ADDR_W'(BASE_ADDR) + ADDR_W'(r_blockCount) * ADDR_W'(LANES)
                    + ADDR_W'(r_lane);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_doneQ   <= 1'b0;
      r_wrPtr   <= 1'b0;
      r_rdPtr   <= 1'b0;
      r_count   <= 2'd0;
      r_overrun <= 1'b0;
    end else begin
      r_doneQ <= accumulator_done;
      if (w_push) r_wrPtr <= ~r_wrPtr;
      if (w_pop)  r_rdPtr <= ~r_rdPtr;
      if (w_drop) r_overrun <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_slot[r_wrPtr] <= in_block;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_lane       <= '0;
      r_blockCount <= 8'd0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        LOAD: begin
          r_shift <= r_slot[r_rdPtr];
          r_lane  <= '0;
        end
        DRAIN: begin
          if (out_ready) begin
            r_shift <= r_shift << WORD_W;
            r_lane  <= r_lane + LANE_W'(1);
          end
        end
        DONE:    r_blockCount <= r_blockCount + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (r_count != 2'd0) w_nextState = LOAD;
      LOAD:    w_nextState = DRAIN;
      DRAIN:   if (out_ready && w_lastLane) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Data and address are forced to zero outside DRAIN so idle outputs read as 0.
  always_comb begin
    out_valid   = (r_state == DRAIN);
    out_word    = '0;
    out_addr    = '0;
    if (out_valid) begin
      out_word = r_shift[BLOCK_W-1 -: WORD_W];
      out_addr = w_addr;
    end
    drain_done  = (r_state == DONE);
    busy        = (r_state != IDLE) || (r_count != 2'd0);
    overrun     = r_overrun;
    block_count = r_blockCount;
  end

endmodule

// File: tb/tb_accum_drain.sv
// Directed bench for accum_drain: capture, backpressure, double buffering,
// overrun, capture-on-pop and reset mid-drain.
module tb_accum_drain;

  logic         clock;
  logic         reset;
  logic         accumulator_done;
  logic [255:0] in_block;
  logic [15:0]  out_word;
  logic [9:0]   out_addr;
  logic         out_valid;
  logic         out_ready;
  logic         drain_done;
  logic         busy;
  logic         overrun;
  logic [7:0]   block_count;

  int           testCount;
  int           failCount;
  logic [31:0]  expWord [64];
  logic [31:0]  expAddr [64];
  logic [255:0] injectBlock;

  accum_drain #(.WORD_W(16), .LANES(16), .ADDR_W(10), .BASE_ADDR(0)) dut (
    .clock            (clock),
    .reset            (reset),
    .accumulator_done (accumulator_done),
    .in_block         (in_block),
    .out_word         (out_word),
    .out_addr         (out_addr),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .drain_done       (drain_done),
    .busy             (busy),
    .overrun          (overrun),
    .block_count      (block_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [255:0] mkRamp(input logic [15:0] base);
    logic [255:0] b;
    for (int i = 0; i < 16; i++) b[255-16*i -: 16] = base + 16'(i);
    return b;
  endfunction

  function automatic logic [255:0] mkFill(input logic [15:0] val);
    logic [255:0] b;
    for (int i = 0; i < 16; i++) b[255-16*i -: 16] = val;
    return b;
  endfunction

  task automatic fillExp(input int startIdx, input logic [255:0] blk, input int startAddr);
    for (int i = 0; i < 16; i++) begin
      expWord[startIdx+i] = {16'h0, blk[255-16*i -: 16]};
      expAddr[startIdx+i] = 32'(startAddr + i);
    end
  endtask

  task automatic applyStimulus(input logic [255:0] blk);
    in_block         = blk;
    accumulator_done = 1'b1;
    tick();
    accumulator_done = 1'b0;
    tick();
  endtask

  task automatic doReset(input string tag);
    reset            = 1'b1;
    accumulator_done = 1'b0;
    out_ready        = 1'b0;
    in_block         = '0;
    tick();
    tick();
    checkOutput($sformatf("%s rst valid", tag), 32'(out_valid), 0);
    checkOutput($sformatf("%s rst word", tag), 32'(out_word), 0);
    checkOutput($sformatf("%s rst addr", tag), 32'(out_addr), 0);
    checkOutput($sformatf("%s rst busy", tag), 32'(busy), 0);
    checkOutput($sformatf("%s rst overrun", tag), 32'(overrun), 0);
    checkOutput($sformatf("%s rst count", tag), 32'(block_count), 0);
    reset = 1'b0;
  endtask

  // Accepts words for a fixed cycle budget, checking order, addresses, stall stability and done pulses.
  task automatic drainCheck(input string tag, input int numWords, input int readyMode,
                            input int cycles, input bit inject);
    int          idx;
    int          dones;
    bit          prevStall;
    logic [31:0] prevWord;
    logic [31:0] prevAddr;
    idx       = 0;
    dones     = 0;
    prevStall = 1'b0;
    prevWord  = '0;
    prevAddr  = '0;
    for (int k = 0; k < cycles; k++) begin
      accumulator_done = 1'b0;
      out_ready = (readyMode == 0) ? 1'b1 : ((k % 3) == 0);
      if (prevStall) begin
        checkOutput($sformatf("%s stall valid k%0d", tag, k), 32'(out_valid), 1);
        checkOutput($sformatf("%s stall word k%0d", tag, k), 32'(out_word), prevWord);
        checkOutput($sformatf("%s stall addr k%0d", tag, k), 32'(out_addr), prevAddr);
      end
      if (out_valid && out_ready) begin
        if (idx < numWords) begin
          checkOutput($sformatf("%s word%0d", tag, idx), 32'(out_word), expWord[idx]);
          checkOutput($sformatf("%s addr%0d", tag, idx), 32'(out_addr), expAddr[idx]);
        end else begin
          checkOutput($sformatf("%s extra word", tag), 1, 0);
        end
        idx++;
      end
      prevStall = out_valid && !out_ready;
      prevWord  = 32'(out_word);
      prevAddr  = 32'(out_addr);
      if (drain_done) begin
        if (inject && dones == 0) begin
          in_block         = injectBlock;
          accumulator_done = 1'b1;
        end
        dones++;
      end
      tick();
    end
    accumulator_done = 1'b0;
    checkOutput($sformatf("%s words", tag), 32'(idx), 32'(numWords));
    checkOutput($sformatf("%s drainDone", tag), 32'(dones), 32'(numWords / 16));
  endtask

  initial begin
    testCount        = 0;
    failCount        = 0;
    reset            = 1'b1;
    accumulator_done = 1'b0;
    out_ready        = 1'b0;
    in_block         = '0;
    injectBlock      = '0;

    $display("[TB] single block");
    doReset("t1");
    fillExp(0, mkRamp(16'h0001), 0);
    in_block         = mkRamp(16'h0001);
    out_ready        = 1'b1;
    accumulator_done = 1'b1;
    tick();
    checkOutput("t1 valid capEdge", 32'(out_valid), 0);
    checkOutput("t1 busy capEdge", 32'(busy), 1);
    in_block = mkFill(16'hDEAD);
    tick();
    checkOutput("t1 valid capEdge+1", 32'(out_valid), 0);
    tick();
    checkOutput("t1 valid capEdge+2", 32'(out_valid), 1);
    accumulator_done = 1'b0;
    drainCheck("t1", 16, 0, 22, 1'b0);
    checkOutput("t1 blockCount", 32'(block_count), 1);
    checkOutput("t1 overrun", 32'(overrun), 0);
    checkOutput("t1 busy end", 32'(busy), 0);

    $display("[TB] backpressure");
    doReset("t2");
    fillExp(0, mkRamp(16'h0001), 0);
    applyStimulus(mkRamp(16'h0001));
    drainCheck("t2", 16, 1, 60, 1'b0);
    checkOutput("t2 blockCount", 32'(block_count), 1);

    $display("[TB] double buffering");
    doReset("t3");
    fillExp(0, mkFill(16'hAAAA), 0);
    fillExp(16, mkFill(16'hBBBB), 16);
    out_ready = 1'b1;
    applyStimulus(mkFill(16'hAAAA));
    in_block         = mkFill(16'hBBBB);
    accumulator_done = 1'b1;
    tick();
    accumulator_done = 1'b0;
    drainCheck("t3", 32, 0, 45, 1'b0);
    checkOutput("t3 blockCount", 32'(block_count), 2);
    checkOutput("t3 overrun", 32'(overrun), 0);

    $display("[TB] overrun");
    doReset("t4");
    fillExp(0, mkFill(16'h1111), 0);
    fillExp(16, mkFill(16'h2222), 16);
    applyStimulus(mkFill(16'h1111));
    applyStimulus(mkFill(16'h2222));
    checkOutput("t4 overrun before", 32'(overrun), 0);
    checkOutput("t4 busy stalled", 32'(busy), 1);
    applyStimulus(mkFill(16'h3333));
    checkOutput("t4 overrun after", 32'(overrun), 1);
    checkOutput("t4 count stalled", 32'(block_count), 0);
    drainCheck("t4", 32, 0, 50, 1'b0);
    checkOutput("t4 blockCount", 32'(block_count), 2);
    checkOutput("t4 overrun sticky", 32'(overrun), 1);
    checkOutput("t4 busy end", 32'(busy), 0);

    $display("[TB] capture on pop");
    doReset("t5");
    fillExp(0, mkFill(16'h0D01), 0);
    fillExp(16, mkFill(16'h0D02), 16);
    fillExp(32, mkRamp(16'h0D30), 32);
    applyStimulus(mkFill(16'h0D01));
    applyStimulus(mkFill(16'h0D02));
    injectBlock = mkRamp(16'h0D30);
    drainCheck("t5", 48, 0, 70, 1'b1);
    checkOutput("t5 overrun", 32'(overrun), 0);
    checkOutput("t5 blockCount", 32'(block_count), 3);

    $display("[TB] reset mid-drain");
    doReset("t6");
    out_ready = 1'b1;
    applyStimulus(mkRamp(16'h0001));
    for (int k = 0; k < 10 && !out_valid; k++) tick();
    checkOutput("t6 validSeen", 32'(out_valid), 1);
    for (int k = 0; k < 5; k++) tick();
    checkOutput("t6 word after 5", 32'(out_word), 32'h0006);
    checkOutput("t6 addr after 5", 32'(out_addr), 5);
    reset = 1'b1;
    tick();
    checkOutput("t6 mid valid", 32'(out_valid), 0);
    checkOutput("t6 mid word", 32'(out_word), 0);
    checkOutput("t6 mid addr", 32'(out_addr), 0);
    checkOutput("t6 mid drainDone", 32'(drain_done), 0);
    checkOutput("t6 mid busy", 32'(busy), 0);
    checkOutput("t6 mid overrun", 32'(overrun), 0);
    checkOutput("t6 mid count", 32'(block_count), 0);
    reset = 1'b0;
    out_ready = 1'b0;
    tick();
    fillExp(0, mkRamp(16'hF000), 0);
    applyStimulus(mkRamp(16'hF000));
    drainCheck("t6", 16, 0, 25, 1'b0);
    checkOutput("t6 blockCount", 32'(block_count), 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
